// File: rtl/cnn_act_stream.sv
// Multi-lane streaming activation stage (bypass / ReLU / leaky / clipped ReLU)
// with a small output FIFO and a saturating counter of negative input elements.
module cnn_act_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int DEPTH      = 2,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES*DATA_WIDTH-1:0] in_data_i,
    input  logic [1:0]                  in_mode_i,
    input  logic [DATA_WIDTH-1:0]       in_clip_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    output logic [LANES*DATA_WIDTH-1:0] out_data_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [CNT_WIDTH-1:0]        neg_count_o,
    input  logic                        clear_i
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int NEG_W  = $clog2(LANES + 1);
    localparam int BEAT_W = LANES * DATA_WIDTH;

    logic [BEAT_W-1:0]            mem_q [DEPTH];
    logic [PTR_W-1:0]             wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]             rdPtr_q, rdPtr_d;
    logic [OCC_W-1:0]             occ_q, occ_d;
    logic [CNT_WIDTH-1:0]         negCnt_q, negCnt_d;

    logic signed [DATA_WIDTH-1:0] clipCeil;
    logic [BEAT_W-1:0]            actBeat;
    logic [LANES-1:0]             laneNeg;
    logic [NEG_W-1:0]             negLanes;
    logic [CNT_WIDTH:0]           negSum;
    logic                         accept;
    logic                         pop;

    // A negative clip ceiling clamps everything to zero.
    assign clipCeil = in_clip_i[DATA_WIDTH-1] ? '0 : signed'(in_clip_i);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] laneX;
        logic signed [DATA_WIDTH-1:0] laneY;

        assign laneX = signed'(in_data_i[g*DATA_WIDTH +: DATA_WIDTH]);

        always_comb begin
            unique case (in_mode_i)
                2'd0:    laneY = laneX;
                2'd1:    laneY = laneX[DATA_WIDTH-1] ? '0 : laneX;
                2'd2:    laneY = laneX[DATA_WIDTH-1] ? (laneX >>> LEAK_SHIFT) : laneX;
                default: laneY = laneX[DATA_WIDTH-1] ? '0 :
                                 ((laneX > clipCeil) ? clipCeil : laneX);
            endcase
        end

        assign actBeat[g*DATA_WIDTH +: DATA_WIDTH] = laneY;
        assign laneNeg[g] = laneX[DATA_WIDTH-1];
    end

    always_comb begin
        negLanes = '0;
        for (int i = 0; i < LANES; i++) begin
            negLanes = negLanes + NEG_W'(laneNeg[i]);
        end
    end

    // Ready depends only on registered occupancy, never on out_ready_i.
    assign in_ready_o  = (occ_q < OCC_W'(DEPTH));
    assign out_valid_o = (occ_q != '0);
    assign out_data_o  = mem_q[rdPtr_q];
    assign neg_count_o = negCnt_q;

    assign accept = in_valid_i && in_ready_o;
    assign pop    = out_valid_o && out_ready_i;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        occ_d   = occ_q;
        if (accept) begin
            wrPtr_d = (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = (rdPtr_q == PTR_W'(DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
        end
        unique case ({accept, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // The extra sum bit flags overflow so the counter sticks at all-ones.
    assign negSum = {1'b0, negCnt_q} + (CNT_WIDTH + 1)'(negLanes);

    always_comb begin
        negCnt_d = negCnt_q;
        if (clear_i) begin
            negCnt_d = '0;
        end else if (accept) begin
            negCnt_d = negSum[CNT_WIDTH] ? '1 : negSum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            occ_q    <= '0;
            negCnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            occ_q    <= occ_d;
            negCnt_q <= negCnt_d;
            if (accept) begin
                mem_q[wrPtr_q] <= actBeat;
            end
        end
    end

endmodule

// File: tb/tb_cnn_act_stream.sv
// Self-checking bench for cnn_act_stream: a queue-based reference model checked
// every cycle, plus directed beats with hand-computed expectations.
module tb_cnn_act_stream;

    localparam int DW    = 32;
    localparam int LANES = 4;
    localparam int DEPTH = 2;
    localparam int LEAK  = 3;
    localparam int BW    = DW * LANES;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] in_data_i = '0;
    logic [1:0]    in_mode_i = '0;
    logic [DW-1:0] in_clip_i = '0;
    logic          in_valid_i = 1'b0;
    logic          out_ready_i = 1'b0;
    logic          clear_i = 1'b0;

    logic          in_ready_o, out_valid_o;
    logic [BW-1:0] out_data_o;
    logic [31:0]   neg_count_o;

    logic          in_ready4, out_valid4;
    logic [BW-1:0] out_data4;
    logic [3:0]    neg_count4;

    int testsRun = 0;
    int testsFailed = 0;
    bit checkEn = 1'b0;

    logic [BW-1:0] expQ[$];
    longint        modelNeg = 0;
    longint        modelNeg4 = 0;
    bit            mAcc, mPop;
    int            mNeg;

    always #5 clk = ~clk;

    cnn_act_stream #(
        .DATA_WIDTH(DW), .LANES(LANES), .DEPTH(DEPTH), .LEAK_SHIFT(LEAK), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data_i(in_data_i), .in_mode_i(in_mode_i), .in_clip_i(in_clip_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .neg_count_o(neg_count_o), .clear_i(clear_i)
    );

    // Narrow-counter build sharing the same stimulus, to exercise saturation.
    cnn_act_stream #(
        .DATA_WIDTH(DW), .LANES(LANES), .DEPTH(DEPTH), .LEAK_SHIFT(LEAK), .CNT_WIDTH(4)
    ) dut4 (
        .clk(clk), .rst(rst),
        .in_data_i(in_data_i), .in_mode_i(in_mode_i), .in_clip_i(in_clip_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready4),
        .out_data_o(out_data4), .out_valid_o(out_valid4), .out_ready_i(out_ready_i),
        .neg_count_o(neg_count4), .clear_i(clear_i)
    );

    function automatic logic [BW-1:0] pack4(int l0, int l1, int l2, int l3);
        return {l3, l2, l1, l0};
    endfunction

    // Reference activation written as plain signed arithmetic per lane.
    function automatic logic [BW-1:0] activateBeat(logic [BW-1:0] data, logic [1:0] mode,
                                                   logic [DW-1:0] clip);
        logic [BW-1:0] res;
        int x, c, y;
        res = '0;
        c = clip;
        if (c < 0) c = 0;
        for (int i = 0; i < LANES; i++) begin
            x = data[i*DW +: DW];
            case (mode)
                2'd0:    y = x;
                2'd1:    y = (x < 0) ? 0 : x;
                2'd2:    y = (x < 0) ? int'($floor(real'(x) / real'(longint'(1) << LEAK))) : x;
                default: y = (x < 0) ? 0 : ((x > c) ? c : x);
            endcase
            res[i*DW +: DW] = y;
        end
        return res;
    endfunction

    function automatic int countNeg(logic [BW-1:0] data);
        int n, x;
        n = 0;
        for (int i = 0; i < LANES; i++) begin
            x = data[i*DW +: DW];
            if (x < 0) n++;
        end
        return n;
    endfunction

    function automatic logic [DW-1:0] randLane();
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1:       return DW'(int'($urandom_range(0, 40)) - 20);
            2:       return ($urandom_range(0, 1) != 0) ? 32'h7FFFFFFF : 32'h80000000;
            default: return DW'(-int'($urandom_range(1, 100)));
        endcase
    endfunction

    function automatic logic [BW-1:0] randBeat();
        logic [BW-1:0] b;
        for (int i = 0; i < LANES; i++) b[i*DW +: DW] = randLane();
        return b;
    endfunction

    function automatic logic [DW-1:0] randClip();
        case ($urandom_range(0, 3))
            0:       return DW'(-int'($urandom_range(0, 50)));
            1:       return $urandom();
            default: return DW'($urandom_range(0, 200));
        endcase
    endfunction

    task automatic checkOutput(string name, logic [BW-1:0] actual, logic [BW-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs just after a rising edge and waits for the next one.
    task automatic applyStimulus(logic v, logic [1:0] mode, logic [DW-1:0] clip,
                                 logic [BW-1:0] data, logic rdy, logic clr);
        in_valid_i  = v;
        in_mode_i   = mode;
        in_clip_i   = clip;
        in_data_i   = data;
        out_ready_i = rdy;
        clear_i     = clr;
        @(posedge clk);
        #1;
    endtask

    // Reference model: advances on each rising edge from the inputs seen there.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            expQ.delete();
            modelNeg  = 0;
            modelNeg4 = 0;
        end else begin
            mAcc = in_valid_i && (expQ.size() < DEPTH);
            mPop = (expQ.size() != 0) && out_ready_i;
            mNeg = countNeg(in_data_i);
            if (mPop) void'(expQ.pop_front());
            if (mAcc) expQ.push_back(activateBeat(in_data_i, in_mode_i, in_clip_i));
            if (clear_i) begin
                modelNeg  = 0;
                modelNeg4 = 0;
            end else if (mAcc) begin
                modelNeg  = (modelNeg + mNeg > 64'hFFFFFFFF) ? 64'hFFFFFFFF : modelNeg + mNeg;
                modelNeg4 = (modelNeg4 + mNeg > 15) ? 15 : modelNeg4 + mNeg;
            end
        end
    end

    // Compare both builds against the model on every falling edge.
    initial forever begin
        @(negedge clk);
        if (checkEn && !rst) begin
            checkOutput("valid", BW'(out_valid_o), BW'(expQ.size() != 0));
            checkOutput("ready", BW'(in_ready_o), BW'(expQ.size() < DEPTH));
            checkOutput("negcnt", BW'(neg_count_o), BW'(modelNeg));
            checkOutput("valid4", BW'(out_valid4), BW'(expQ.size() != 0));
            checkOutput("ready4", BW'(in_ready4), BW'(expQ.size() < DEPTH));
            checkOutput("negcnt4", BW'(neg_count4), BW'(modelNeg4));
            if (expQ.size() != 0) begin
                checkOutput("data", out_data_o, expQ[0]);
                checkOutput("data4", out_data4, expQ[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [BW-1:0] beatM, negBeat;
        logic [BW-1:0] b1, b2, b3, b4;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkEn = 1'b1;
        checkOutput("rst_valid", BW'(out_valid_o), BW'(0));
        checkOutput("rst_ready", BW'(in_ready_o), BW'(1));
        checkOutput("rst_neg", BW'(neg_count_o), BW'(0));
        checkOutput("rst_data", out_data_o, '0);

        applyStimulus(1, 2'd1, '0, pack4(-5, 0, 7, 32'h7FFFFFFF), 1, 0);
        checkOutput("single_data", out_data_o, pack4(0, 0, 7, 32'h7FFFFFFF));
        checkOutput("single_valid", BW'(out_valid_o), BW'(1));
        checkOutput("single_neg", BW'(neg_count_o), BW'(1));
        applyStimulus(0, 2'd0, '0, '0, 1, 0);
        checkOutput("single_gone", BW'(out_valid_o), BW'(0));

        beatM = pack4(-9, -1, 100, 3);
        applyStimulus(1, 2'd0, 32'd50, beatM, 1, 0);
        checkOutput("mode0", out_data_o, pack4(-9, -1, 100, 3));
        applyStimulus(1, 2'd2, 32'd50, beatM, 1, 0);
        checkOutput("mode2", out_data_o, pack4(-2, -1, 100, 3));
        checkOutput("mode2_valid", BW'(out_valid_o), BW'(1));
        applyStimulus(1, 2'd3, 32'd50, beatM, 1, 0);
        checkOutput("mode3", out_data_o, pack4(0, 0, 50, 3));
        checkOutput("mode3_valid", BW'(out_valid_o), BW'(1));
        applyStimulus(1, 2'd3, DW'(-4), beatM, 1, 0);
        checkOutput("mode3_negclip", out_data_o, '0);
        checkOutput("mode3n_valid", BW'(out_valid_o), BW'(1));
        applyStimulus(0, 2'd0, '0, '0, 1, 0);
        checkOutput("modes_neg", BW'(neg_count_o), BW'(9));

        b1 = pack4(11, -12, 13, 14);
        b2 = pack4(21, 22, -23, 24);
        b3 = pack4(31, 32, 33, -34);
        b4 = pack4(-41, 42, 43, 44);
        applyStimulus(1, 2'd0, '0, b1, 0, 0);
        applyStimulus(1, 2'd0, '0, b2, 0, 0);
        checkOutput("bp_full_ready", BW'(in_ready_o), BW'(0));
        checkOutput("bp_head1", out_data_o, b1);
        applyStimulus(1, 2'd0, '0, b3, 0, 0);
        checkOutput("bp_stable", out_data_o, b1);
        checkOutput("bp_still_full", BW'(in_ready_o), BW'(0));
        applyStimulus(1, 2'd0, '0, b3, 1, 0);
        checkOutput("bp_out2", out_data_o, b2);
        applyStimulus(1, 2'd0, '0, b3, 1, 0);
        checkOutput("bp_out3", out_data_o, b3);
        applyStimulus(1, 2'd0, '0, b4, 1, 0);
        checkOutput("bp_out4", out_data_o, b4);
        applyStimulus(0, 2'd0, '0, '0, 1, 0);
        checkOutput("bp_drained", BW'(out_valid_o), BW'(0));
        checkOutput("bp_neg", BW'(neg_count_o), BW'(13));

        for (int i = 0; i < 30; i++) begin
            applyStimulus(1, 2'($urandom_range(0, 3)), randClip(), randBeat(), 1, 0);
        end
        applyStimulus(0, 2'd0, '0, '0, 1, 0);

        applyStimulus(1, 2'($urandom_range(0, 3)), randClip(), randBeat(), 0, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 2'($urandom_range(0, 3)), randClip(), randBeat(), 1, 0);
            checkOutput("c1_ready", BW'(in_ready_o), BW'(1));
            checkOutput("c1_valid", BW'(out_valid_o), BW'(1));
        end
        applyStimulus(0, 2'd0, '0, '0, 1, 0);

        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), randClip(),
                          randBeat(), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end
        applyStimulus(0, 2'd0, '0, '0, 1, 0);
        applyStimulus(0, 2'd0, '0, '0, 1, 0);

        applyStimulus(0, 2'd0, '0, '0, 1, 1);
        checkOutput("clr_neg", BW'(neg_count_o), BW'(0));
        checkOutput("clr_neg4", BW'(neg_count4), BW'(0));
        negBeat = pack4(-1, -2, -3, -4);
        repeat (4) applyStimulus(1, 2'd1, '0, negBeat, 1, 0);
        checkOutput("sat_neg4", BW'(neg_count4), BW'(15));
        checkOutput("sat_neg", BW'(neg_count_o), BW'(16));
        applyStimulus(1, 2'd1, '0, negBeat, 1, 0);
        checkOutput("sat_hold4", BW'(neg_count4), BW'(15));
        checkOutput("sat_neg20", BW'(neg_count_o), BW'(20));
        applyStimulus(1, 2'd1, '0, negBeat, 1, 1);
        checkOutput("clr_wins", BW'(neg_count_o), BW'(0));
        checkOutput("clr_wins4", BW'(neg_count4), BW'(0));
        checkOutput("clr_beat_out", out_data_o, '0);
        applyStimulus(0, 2'd0, '0, '0, 1, 0);

        applyStimulus(1, 2'd0, '0, b1, 0, 0);
        applyStimulus(1, 2'd0, '0, b2, 0, 0);
        checkOutput("pre_rst_full", BW'(in_ready_o), BW'(0));
        in_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", BW'(out_valid_o), BW'(0));
        checkOutput("mid_rst_ready", BW'(in_ready_o), BW'(1));
        checkOutput("mid_rst_neg", BW'(neg_count_o), BW'(0));
        checkOutput("mid_rst_data", out_data_o, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1, 2'd2, '0, pack4(-9, -16, 5, -1), 1, 0);
        checkOutput("post_rst_data", out_data_o, pack4(-2, -2, 5, -1));
        checkOutput("post_rst_valid", BW'(out_valid_o), BW'(1));
        checkOutput("post_rst_neg", BW'(neg_count_o), BW'(3));
        applyStimulus(0, 2'd0, '0, '0, 1, 0);
        applyStimulus(0, 2'd0, '0, '0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
